dp_bram_pipe: RTL and testbench
===============================

# dp_bram_pipe

Parametrised true dual-port block RAM, the next-generation line/frame storage primitive for the 2D FIR datapath. It generalises data width, depth and read latency, and adds per-port enables with read-valid tracking. It also defines deterministic same-address collision behaviour, out-of-range protection and an optional post-reset memory clear sequencer. Both ports share one clock; window and line-buffer logic sits on either port.

## Interface
- DATA_W, 8, data word width in bits (1..64)
- ADDR_W, 11, address width in bits
- DEPTH, 2048, number of words; DEPTH <= 2**ADDR_W
- RD_LAT, 1, read latency in cycles; only 1 or 2 legal, other values are an elaboration error
- CLR_VAL, 0, DATA_W-wide word written to every location by the clear sequencer
---
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en_a / en_b  in  1  port access enable
- we_a / we_b  in  1  write enable, qualified by en_x
- addr_a / addr_b  in  ADDR_W  word address
- din_a / din_b  in  DATA_W  write data
- dout_a / dout_b  out  DATA_W  read data
- rvalid_a / rvalid_b  out  1  dout_x carries the result of a read issued RD_LAT cycles earlier
- init_busy  out  1  clear sequence in progress, all port accesses ignored
- collision  out  1  one-cycle pulse, both ports wrote the same address

## Operation
- A read is en_x=1, we_x=0. A write is en_x=1, we_x=1.
- Read-first on both ports: a read returns the array content before any same-cycle write to that address, from either port. A write also updates dout_x with the old content, with rvalid_x=0.
- dout_x holds its last value when no read completes. rvalid_x is high exactly one cycle per completed read.
- Out of range means addr_x >= DEPTH:
  - A write there is dropped.
  - A read there completes normally with dout_x = 0.
- A write-write collision means both ports write the same in-range address in the same cycle. Port A's data is stored and port B's is dropped. collision=1 on the next cycle. Read/read and read/write on the same address never flag.
- While init_busy=1, en_a and en_b are ignored: no writes, no rvalid.
- Clear FSM with DP_BRAM_CLEAR_EN defined:
  - CLEAR: entered on reset. Writes CLR_VAL to address cnt, and cnt increments. Moves to READY after writing DEPTH-1.
  - READY: terminal state; init_busy=0.
- Width rules: the clear counter is ADDR_W+1 bits; no arithmetic is done on the data.

## Timing
- Reset values: dout_a=dout_b=0, rvalid_a=rvalid_b=0, collision=0, FSM=CLEAR, cnt=0. init_busy=1 with DP_BRAM_CLEAR_EN, else 0.
- The memory array is not reset.
- RD_LAT=1: read sampled at edge N, dout/rvalid valid after edge N (registered array output).
- RD_LAT=2: one additional output register stage, valid after edge N+1. Back-to-back reads every cycle give one result per cycle.
- Clear takes exactly DEPTH cycles after rst_n deasserts. init_busy falls after the edge that writes address DEPTH-1, and the first access is accepted on the next edge.
- Reset asserted mid-clear or mid-read:
  - Pipeline valids clear immediately.
  - The FSM restarts at address 0.
  - In-flight reads are lost.

## Configuration
- DP_BRAM_CLEAR_EN is the only configuration macro.
- With DP_BRAM_CLEAR_EN defined: the clear FSM and counter are present and behave as above.
- Without DP_BRAM_CLEAR_EN: no FSM, init_busy is tied 0, memory contents after power-up are undefined, and ports are usable on the first edge after rst_n deasserts.

## Structure
- Package dp_bram_pkg holds:
  - the clear FSM state encoding (CLEAR, READY);
  - RD_LAT legal-value constants;
  - the out-of-range read return constant (0).
- Sub-module dp_bram_rd_pipe holds the per-port output/valid pipeline (1 or 2 stages) and is instantiated once per port. The array and the collision logic stay in the top level.

## Test plan
- Clear, DEPTH=16, CLR_VAL=8'hA5, macro on: release reset. init_busy stays high exactly 16 cycles. Reading all 16 addresses then returns 8'hA5 each.
- Read latency, RD_LAT=1 then RD_LAT=2:
  - Write 8'h3C to address 5 on port A, then read address 5 on port B.
  - Expect dout_b=8'h3C with rvalid_b high 1 and 2 cycles after the read, respectively.
  - Streaming 8 reads gives 8 consecutive rvalid pulses.
- Read-first: address 7 holds 8'h11. Port A writes 8'h22 to address 7 while port B reads address 7 in the same cycle. Expect dout_b=8'h11, and a following read returns 8'h22.
- Collision: both ports write address 9 in the same cycle, A=8'hAA and B=8'hBB. Expect collision=1 for one cycle and a later read of address 9 to return 8'hAA.
- Out of range, DEPTH=16: write 8'hFF to address 20, then read address 20. Expect rvalid with dout=0, and all in-range contents unchanged.
- Reset mid-clear: assert rst_n=0 at clear address 6. Expect rvalid=0, then after release a full 16-cycle clear restarting from address 0. With the macro off, expect init_busy=0 throughout.

Source files
------------

// File: rtl/dp_bram_pkg.sv
// Shared types and constants for the dp_bram_pipe dual-port RAM.
// Clear FSM encoding, legal read latencies and the out-of-range read word.
package dp_bram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_e;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 2;

    // Word returned by a read whose address is beyond DEPTH; sliced to DATA_W at use.
    localparam logic [63:0] OOR_RD_WORD = 64'h0;

    function automatic logic rd_lat_legal(input int unsigned lat);
        return (lat == RD_LAT_MIN) || (lat == RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/dp_bram_rd_pipe.sv
// Per-port read data / read-valid pipeline of dp_bram_pipe, one or two register stages.
// Accepted writes refresh the data path with the old word but never raise rvalid.
module dp_bram_rd_pipe
    import dp_bram_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              acc,
    input  logic              rd,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] dout,
    output logic              rvalid
);

    logic [DATA_W-1:0] s1_data;
    logic              s1_vld;

    // First stage: captures the array word for every accepted access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_data <= '0;
            s1_vld  <= 1'b0;
        end else begin
            s1_vld <= acc & rd;
            if (acc) begin
                s1_data <= data;
            end
        end
    end

    if (RD_LAT == RD_LAT_MAX) begin : g_two_stage
        logic s1_upd;

        // Second stage only moves when the first stage was loaded, so dout holds otherwise.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_upd <= 1'b0;
                dout   <= '0;
                rvalid <= 1'b0;
            end else begin
                s1_upd <= acc;
                rvalid <= s1_vld;
                if (s1_upd) begin
                    dout <= s1_data;
                end
            end
        end
    end else begin : g_one_stage
        assign dout   = s1_data;
        assign rvalid = s1_vld;
    end

endmodule

// File: rtl/dp_bram_pipe.sv
// True dual-port RAM, read-first on both ports, A wins write-write collisions.
// Optional post-reset clear sequencer enabled by defining DP_BRAM_CLEAR_EN.
module dp_bram_pipe
    import dp_bram_pkg::*;
#(
    parameter int unsigned       DATA_W  = 8,
    parameter int unsigned       ADDR_W  = 11,
    parameter int unsigned       DEPTH   = 2048,
    parameter int unsigned       RD_LAT  = 1,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] din_a,
    output logic [DATA_W-1:0] dout_a,
    output logic              rvalid_a,
    input  logic              en_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] din_b,
    output logic [DATA_W-1:0] dout_b,
    output logic              rvalid_b,
    output logic              init_busy,
    output logic              collision
);

    localparam int unsigned       IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LAST_W   = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0]   ONE_W    = (ADDR_W + 1)'(1);
    localparam logic [DATA_W-1:0] OOR_WORD = DATA_W'(OOR_RD_WORD);

    if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
        $error("dp_bram_pipe: RD_LAT must be 1 or 2");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic              acc_a, acc_b;
    logic              in_a, in_b;
    logic              wr_a, wr_b;
    logic [IDX_W-1:0]  idx_a, idx_b;
    logic              clr_we;
    logic [IDX_W-1:0]  clr_idx;
    logic              wa_en;
    logic [IDX_W-1:0]  wa_idx;
    logic [DATA_W-1:0] wa_data;
    logic [DATA_W-1:0] rd_a_c, rd_b_c;

    assign acc_a = en_a & ~init_busy;
    assign acc_b = en_b & ~init_busy;
    assign in_a  = ({1'b0, addr_a} < DEPTH_W);
    assign in_b  = ({1'b0, addr_b} < DEPTH_W);
    assign idx_a = addr_a[IDX_W-1:0];
    assign idx_b = addr_b[IDX_W-1:0];

    // Port B yields to a same-address port A write; out-of-range writes are dropped.
    assign wr_a = acc_a & we_a & in_a;
    assign wr_b = acc_b & we_b & in_b & ~(wr_a && (addr_a == addr_b));

`ifdef DP_BRAM_CLEAR_EN
    clr_state_e      state;
    logic [ADDR_W:0] cnt;

    // Clear sequencer: one word per cycle from address 0, then parks in READY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CLEAR;
            cnt       <= '0;
            init_busy <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    cnt <= cnt + ONE_W;
                    if (cnt == LAST_W) begin
                        state     <= READY;
                        init_busy <= 1'b0;
                    end
                end
                READY:   ;
                default: state <= READY;
            endcase
        end
    end

    assign clr_we  = (state == CLEAR);
    assign clr_idx = cnt[IDX_W-1:0];
`else
    assign init_busy = 1'b0;
    assign clr_we    = 1'b0;
    assign clr_idx   = '0;
`endif

    // The clear sequencer borrows the port A write path while ports are blocked.
    assign wa_en   = clr_we | wr_a;
    assign wa_idx  = clr_we ? clr_idx : idx_a;
    assign wa_data = clr_we ? CLR_VAL : din_a;

    always_ff @(posedge clk) begin
        if (wa_en) begin
            mem[wa_idx] <= wa_data;
        end
        if (wr_b) begin
            mem[idx_b] <= din_b;
        end
    end

    // Pre-edge array contents give read-first behaviour for both ports.
    assign rd_a_c = in_a ? mem[idx_a] : OOR_WORD;
    assign rd_b_c = in_b ? mem[idx_b] : OOR_WORD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            collision <= 1'b0;
        end else begin
            collision <= acc_a & we_a & in_a & acc_b & we_b & (addr_a == addr_b);
        end
    end

    dp_bram_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_pipe_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .acc    (acc_a),
        .rd     (~we_a),
        .data   (rd_a_c),
        .dout   (dout_a),
        .rvalid (rvalid_a)
    );

    dp_bram_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_pipe_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .acc    (acc_b),
        .rd     (~we_b),
        .data   (rd_b_c),
        .dout   (dout_b),
        .rvalid (rvalid_b)
    );

endmodule

// File: tb/tb_dp_bram_pipe.sv
// Scoreboard bench for dp_bram_pipe: one instance per legal read latency, shared stimulus.
// Expected words come from a plain array model of the memory; works with or without DP_BRAM_CLEAR_EN.
module tb_dp_bram_pipe;

    localparam int DEPTH = 16;
`ifdef DP_BRAM_CLEAR_EN
    localparam bit CLR_ON = 1'b1;
`else
    localparam bit CLR_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en_a, we_a, en_b, we_b;
    logic [4:0] addr_a, addr_b;
    logic [7:0] din_a, din_b;
    logic [7:0] dout_a1, dout_b1, dout_a2, dout_b2;
    logic       rvalid_a1, rvalid_b1, rvalid_a2, rvalid_b2;
    logic       init_busy1, init_busy2, collision1, collision2;

    always #5 clk = ~clk;

    dp_bram_pipe #(.DATA_W(8), .ADDR_W(5), .DEPTH(DEPTH), .RD_LAT(1), .CLR_VAL(8'hA5)) u_lat1 (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a1), .rvalid_a(rvalid_a1),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b1), .rvalid_b(rvalid_b1),
        .init_busy(init_busy1), .collision(collision1));

    dp_bram_pipe #(.DATA_W(8), .ADDR_W(5), .DEPTH(DEPTH), .RD_LAT(2), .CLR_VAL(8'hA5)) u_lat2 (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a2), .rvalid_a(rvalid_a2),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b2), .rvalid_b(rvalid_b2),
        .init_busy(init_busy2), .collision(collision2));

    typedef struct {
        logic [7:0] data;
        bit         wr;
        bit         chk;
        int         due;
    } exp_t;

    exp_t       q[4][$];          // index = (latency-1)*2 + port
    bit         cq[$];
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    logic [7:0] mdl[DEPTH];
    bit         known[DEPTH];
    bit         accepting = 1'b0;

    wire [3:0] rv_v = {rvalid_b2, rvalid_a2, rvalid_b1, rvalid_a1};

    function automatic logic [7:0] dsel(input int i);
        case (i)
            0:       return dout_a1;
            1:       return dout_b1;
            2:       return dout_a2;
            default: return dout_b2;
        endcase
    endfunction

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops one expectation per port when it falls due, flags any unexpected rvalid.
    always @(posedge clk) begin : mon
        exp_t e;
        bit   c;
        #1;
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (q[i].size() > 0 && q[i][0].due <= cyc) begin
                    e = q[i].pop_front();
                    check($sformatf("rvalid_q%0d", i), 64'(rv_v[i]), 64'(!e.wr));
                    check($sformatf("due_q%0d", i), 64'(e.due), 64'(cyc));
                    if (e.chk) check($sformatf("dout_q%0d", i), 64'(dsel(i)), 64'(e.data));
                end else if (rv_v[i]) begin
                    check($sformatf("spurious_rvalid_q%0d", i), 64'(rv_v[i]), 64'(0));
                end
            end
            if (cq.size() > 0) begin
                c = cq.pop_front();
                check("collision_lat1", 64'(collision1), 64'(c));
                check("collision_lat2", 64'(collision2), 64'(c));
            end
        end
    end

    // One clock of stimulus; the model applies read-first, then B's write, then A's (A wins).
    task automatic drive(input bit ea, input bit wa, input int aa, input logic [7:0] da,
                         input bit eb, input bit wb, input int ab, input logic [7:0] db);
        exp_t e;
        en_a = ea; we_a = wa; addr_a = 5'(aa); din_a = da;
        en_b = eb; we_b = wb; addr_b = 5'(ab); din_b = db;
        if (accepting) begin
            for (int lat = 1; lat <= 2; lat++) begin
                if (ea) begin
                    e.data = (aa < DEPTH) ? mdl[aa] : 8'h00;
                    e.chk  = (aa >= DEPTH) || known[aa];
                    e.wr   = wa;
                    e.due  = cyc + lat;
                    q[(lat - 1) * 2].push_back(e);
                end
                if (eb) begin
                    e.data = (ab < DEPTH) ? mdl[ab] : 8'h00;
                    e.chk  = (ab >= DEPTH) || known[ab];
                    e.wr   = wb;
                    e.due  = cyc + lat;
                    q[(lat - 1) * 2 + 1].push_back(e);
                end
            end
            cq.push_back(ea && wa && eb && wb && (aa == ab) && (aa < DEPTH));
            if (eb && wb && ab < DEPTH) begin mdl[ab] = db; known[ab] = 1'b1; end
            if (ea && wa && aa < DEPTH) begin mdl[aa] = da; known[aa] = 1'b1; end
        end else begin
            cq.push_back(1'b0);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
    endtask

    task automatic read_all_b();
        for (int a = 0; a < DEPTH; a++) drive(0, 0, 0, 8'h00, 1, 0, a, 8'h00);
    endtask

    initial begin
        int n;
        int aa, ab;
        en_a = 0; we_a = 0; addr_a = '0; din_a = '0;
        en_b = 0; we_b = 0; addr_b = '0; din_b = '0;
        for (int a = 0; a < DEPTH; a++) known[a] = 1'b0;
        repeat (2) @(negedge clk);

        check("reset_outs_lat1", {dout_a1, dout_b1, rvalid_a1, rvalid_b1, collision1}, 64'(0));
        check("reset_outs_lat2", {dout_a2, dout_b2, rvalid_a2, rvalid_b2, collision2}, 64'(0));
        check("reset_busy", 64'({init_busy1, init_busy2}), CLR_ON ? 64'(3) : 64'(0));

        // Run part of a clear (with blocked accesses), then reset at clear address 6.
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (CLR_ON) drive(1, i[0], $urandom_range(0, 15), 8'($urandom), 1, 0, $urandom_range(0, 15), 8'h00);
            else        idle(1);
        end
        rst_n = 1'b0;
        #1;
        check("midclear_rst_rvalid", 64'(rv_v), 64'(0));
        check("midclear_rst_busy", 64'(init_busy1), 64'(CLR_ON));
        en_a = 0; en_b = 0; we_a = 0; we_b = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while ((init_busy1 || init_busy2) && n < 100);
        check("clear_cycles", 64'(n), CLR_ON ? 64'(DEPTH) : 64'(1));
        @(negedge clk);
        accepting = 1'b1;

        if (CLR_ON) begin
            for (int a = 0; a < DEPTH; a++) begin mdl[a] = 8'hA5; known[a] = 1'b1; end
        end else begin
            for (int a = 0; a < DEPTH; a += 2) drive(1, 1, a, 8'($urandom), 1, 1, a + 1, 8'($urandom));
        end
        read_all_b();

        // Latency check: write A, read B.
        drive(1, 1, 5, 8'h3C, 0, 0, 0, 8'h00);
        drive(0, 0, 0, 8'h00, 1, 0, 5, 8'h00);
        idle(2);
        // Read-first across ports.
        drive(1, 1, 7, 8'h11, 0, 0, 0, 8'h00);
        drive(1, 1, 7, 8'h22, 1, 0, 7, 8'h00);
        drive(1, 0, 7, 8'h00, 0, 0, 0, 8'h00);
        // Write-write collision.
        drive(1, 1, 9, 8'hAA, 1, 1, 9, 8'hBB);
        idle(1);
        drive(1, 0, 9, 8'h00, 1, 0, 9, 8'h00);
        // Out-of-range write then read, then full sweep.
        drive(1, 1, 20, 8'hFF, 0, 0, 0, 8'h00);
        drive(0, 0, 0, 8'h00, 1, 0, 20, 8'h00);
        read_all_b();

        repeat (400) begin
            aa = $urandom_range(0, 23);
            ab = ($urandom_range(0, 3) == 0) ? aa : $urandom_range(0, 23);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, aa, 8'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, ab, 8'($urandom));
        end
        read_all_b();
        idle(4);

        check("scoreboard_drained", 64'(q[0].size() + q[1].size() + q[2].size() + q[3].size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
